skid_pipe_reg: RTL and testbench
================================

SKID_PIPE_REG -- requirements
Module: skid_pipe_reg

Interface
REQ-001 The parameter list SHALL be exactly:
- DATA_W, default 64: payload width; the {pc, instr} bundle.
- NOP_VALUE, default {32'h0, 32'h00000013}: payload presented when the stage is empty or flushed.
- SKID, default 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
- CNT_W, default 16: stall counter width.

REQ-002 The port list SHALL be exactly (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- flush, in, 1: synchronous discard of all held entries.
- in_valid, in, 1: upstream offers in_data.
- in_ready, out, 1: stage accepts in_data this cycle.
- in_data, in, DATA_W: upstream payload.
- out_valid, out, 1: out_data holds a valid entry.
- out_ready, in, 1: downstream consumes out_data this cycle.
- out_data, out, DATA_W: head entry payload.
- occupancy, out, 2: entries held, 0..2.
- stall_cnt, out, CNT_W: saturating count of back-pressure cycles.

Function
REQ-003 An accept SHALL occur when in_valid && in_ready; a consume SHALL occur when out_valid && out_ready; both are sampled at the rising clk edge.
REQ-004 Accept-to-output latency SHALL be exactly 1 cycle: an entry accepted at edge N is visible on out_data with out_valid=1 after edge N, provided it is the head entry.
REQ-005 Entries SHALL leave in acceptance order; there is no loss and no duplication.
REQ-006 With SKID=1, the state SHALL be one of EMPTY (occupancy 0), ONE (occupancy 1, main register valid) or TWO (occupancy 2, main and skid registers valid).
REQ-007 With SKID=1, in_ready SHALL be a register output equal to (state != TWO), with no combinational path from out_ready.
REQ-008 SKID=1 state transitions SHALL be:
- EMPTY + accept -> ONE.
- ONE + accept without consume -> TWO; the new entry goes to skid.
- ONE + consume without accept -> EMPTY.
- ONE + accept and consume -> ONE; main is loaded with in_data.
- TWO + consume -> ONE; main is loaded from skid.
- All other combinations hold state.
REQ-009 With SKID=0, only EMPTY and ONE SHALL exist, and in_ready SHALL equal !out_valid || out_ready; accept and consume in the same cycle keeps ONE.
REQ-010 out_valid SHALL equal (state != EMPTY).
REQ-011 out_data SHALL equal NOP_VALUE whenever state is EMPTY.
REQ-012 When flush=1 at an edge, the next state SHALL be EMPTY and both registers SHALL load NOP_VALUE. Any accept or consume in that cycle is discarded; flush has priority over all other events.
REQ-013 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, and flush=0. It SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-014 stall_cnt SHALL be cleared only by reset; flush does not clear it.
REQ-015 in_ready SHALL NOT depend on in_valid.

Reset
REQ-016 While reset=1, the stage SHALL asynchronously hold: state EMPTY, out_valid=0, out_data=NOP_VALUE, skid register=NOP_VALUE, occupancy=0, stall_cnt=0.
REQ-017 While reset=1, in_ready SHALL be 0. It SHALL rise at the first clk edge after reset deasserts.
REQ-018 Reset asserted while in TWO SHALL drop both entries; no partial entry SHALL appear after release.

Structure
REQ-019 A shared package pipe_pkg SHALL hold the RV_NOP constant (32'h00000013) and the stage state enumeration {EMPTY, ONE, TWO}.
REQ-020 The stall counter SHALL be a sub-module sat_counter, parametrised by width, with ports inc, clr (async) and count.
REQ-021 The if_id stage SHALL be an instance with DATA_W=64; pc occupies bits [63:32] and instr occupies bits [31:0].

Verification
REQ-022 Reset release, then in_valid=1 with in_data=64'h0000_0100_0000_00B3 and out_ready=1 -> out_valid=1 and out_data=64'h0000_0100_0000_00B3 one cycle later; occupancy=1.
REQ-023 SKID=1, out_ready=0, 3 consecutive offers A, B, C -> A and B accepted, in_ready=0 after the second accept, C held upstream, occupancy=2; then out_ready=1 -> out_data sequence A, B, C with no gap.
REQ-024 Occupancy 2 with flush=1 and in_valid=1 in the same cycle -> next cycle occupancy=0, out_valid=0, out_data=64'h0000_0000_0000_0013, in_ready=1.
REQ-025 CNT_W=4, out_valid=1, out_ready=0 held for 20 cycles -> stall_cnt reads 15 and stays 15; flush leaves it at 15; reset -> 0.
REQ-026 SKID=0, continuous in_valid=1 and out_ready=1 for 8 entries -> 8 outputs on consecutive cycles, in order, with in_ready=1 throughout.
REQ-027 Reset asserted mid-cycle while in TWO -> out_valid=0 immediately, without waiting for a clk edge; after release out_data=NOP_VALUE and occupancy=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the RISC-V canonical NOP and the stage occupancy states.
package pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Encoding doubles as the occupancy count, so the top can export it directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/skid_pipe_reg_if.sv
// Handshake bundle for one pipeline stage: upstream valid/ready/data and downstream valid/ready/data.
interface skid_pipe_reg_if #(
  parameter int unsigned DATA_W = 64
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/skid_pipe_reg.sv
// Pipeline register stage with optional 2-entry skid buffer, flush and a back-pressure counter.
module skid_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {32'h0, RV_NOP},
  parameter int unsigned       SKID      = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              consume;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (accept && consume) begin
            main_d = in_data;
          end else if (consume) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        TWO: begin
          if (consume) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  // In single-register mode ready_q only marks "out of reset"; the handshake itself is combinational.
  assign ready_d = (SKID != 0) ? (state_d != TWO) : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ready_q;
    end else begin : g_single
      assign in_ready = ready_q && (!out_valid || out_ready);
    end
  endgenerate

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (reset),
    .inc  (out_valid && !out_ready && !flush),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Bench for skid_pipe_reg: a skid instance (if_id, CNT_W=4) and a single-register instance, scoreboard-checked.
`timescale 1ns/1ps
module tb_skid_pipe_reg;
  import pipe_pkg::*;

  localparam logic [63:0] NOP = {32'h0, RV_NOP};

  logic        clk = 1'b0;
  logic        reset;
  logic        flush1, flush0;
  logic [1:0]  occ1, occ0;
  logic [3:0]  stall1;
  logic [15:0] stall0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb1[$];
  logic [63:0] sb0[$];
  logic [63:0] exp1, exp0;

  skid_pipe_reg_if #(.DATA_W(64)) bus1 ();
  skid_pipe_reg_if #(.DATA_W(64)) bus0 ();

  always #5 clk = ~clk;

  skid_pipe_reg #(.DATA_W(64), .NOP_VALUE(NOP), .SKID(1), .CNT_W(4)) if_id (
    .clk(clk), .reset(reset), .flush(flush1),
    .in_valid(bus1.in_valid), .in_ready(bus1.in_ready), .in_data(bus1.in_data),
    .out_valid(bus1.out_valid), .out_ready(bus1.out_ready), .out_data(bus1.out_data),
    .occupancy(occ1), .stall_cnt(stall1)
  );

  skid_pipe_reg #(.DATA_W(64), .NOP_VALUE(NOP), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .reset(reset), .flush(flush0),
    .in_valid(bus0.in_valid), .in_ready(bus0.in_ready), .in_data(bus0.in_data),
    .out_valid(bus0.out_valid), .out_ready(bus0.out_ready), .out_data(bus0.out_data),
    .occupancy(occ0), .stall_cnt(stall0)
  );

  // Scoreboard for the skid instance: inputs are stable at negedge, so these reflect the coming edge.
  always @(negedge clk) begin
    if (reset || flush1) begin
      sb1.delete();
    end else begin
      if (bus1.out_valid && bus1.out_ready) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb1_order: got %h, nothing expected", bus1.out_data);
        end else begin
          exp1 = sb1.pop_front();
          if (bus1.out_data !== exp1) begin
            errors++;
            $display("[TB] FAIL sb1_order: got %h want %h", bus1.out_data, exp1);
          end
        end
      end
      if (bus1.in_valid && bus1.in_ready) sb1.push_back(bus1.in_data);
    end
  end

  always @(negedge clk) begin
    if (reset || flush0) begin
      sb0.delete();
    end else begin
      if (bus0.out_valid && bus0.out_ready) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb0_order: got %h, nothing expected", bus0.out_data);
        end else begin
          exp0 = sb0.pop_front();
          if (bus0.out_data !== exp0) begin
            errors++;
            $display("[TB] FAIL sb0_order: got %h want %h", bus0.out_data, exp0);
          end
        end
      end
      if (bus0.in_valid && bus0.in_ready) sb0.push_back(bus0.in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush1 = 1'b0; flush0 = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    tick();
    tick();
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", bus1.out_valid); end
    checks++; if (bus1.out_data !== NOP) begin errors++; $display("[TB] FAIL rst_data: got %h want %h", bus1.out_data, NOP); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("[TB] FAIL rst_occ: got %0d want 0", occ1); end
    checks++; if (stall1 !== 4'd0) begin errors++; $display("[TB] FAIL rst_stall: got %0d want 0", stall1); end
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready1: got %b want 0", bus1.in_ready); end
    checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready0: got %b want 0", bus0.in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rel_ready_early: got %b want 0", bus1.in_ready); end
    tick();
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_ready1: got %b want 1", bus1.in_ready); end
    checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_ready0: got %b want 1", bus0.in_ready); end
  endtask

  task automatic test_first_accept();
    bus1.in_valid = 1'b1; bus1.in_data = 64'h0000_0100_0000_00B3; bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b want 1", bus1.out_valid); end
    checks++; if (bus1.out_data !== 64'h0000_0100_0000_00B3) begin errors++; $display("[TB] FAIL first_data: got %h want 00000100000000b3", bus1.out_data); end
    checks++; if (occ1 !== 2'd1) begin errors++; $display("[TB] FAIL first_occ: got %0d want 1", occ1); end
    tick();
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid: got %b want 0", bus1.out_valid); end
    checks++; if (bus1.out_data !== NOP) begin errors++; $display("[TB] FAIL drain_nop: got %h want %h", bus1.out_data, NOP); end
    checks++; if (stall1 !== 4'd0) begin errors++; $display("[TB] FAIL first_stall: got %0d want 0", stall1); end
  endtask

  task automatic test_skid_fill();
    logic [63:0] vals [3];
    vals[0] = 64'hAAAA_0000_0000_0001;
    vals[1] = 64'hBBBB_0000_0000_0002;
    vals[2] = 64'hCCCC_0000_0000_0003;
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus1.in_data = vals[i];
      tick();
    end
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_ready: got %b want 0", bus1.in_ready); end
    checks++; if (occ1 !== 2'd2) begin errors++; $display("[TB] FAIL skid_occ: got %0d want 2", occ1); end
    checks++; if (bus1.out_data !== vals[0]) begin errors++; $display("[TB] FAIL skid_head: got %h want %h", bus1.out_data, vals[0]); end
    checks++; if (stall1 !== 4'd2) begin errors++; $display("[TB] FAIL skid_stall: got %0d want 2", stall1); end
    bus1.out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      if (i == 2) bus1.in_valid = 1'b0;
      checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== vals[i]) begin
        errors++; $display("[TB] FAIL skid_seq%0d: got v=%b %h want v=1 %h", i, bus1.out_valid, bus1.out_data, vals[i]);
      end
    end
    tick();
    checks++; if (occ1 !== 2'd0) begin errors++; $display("[TB] FAIL skid_empty: got %0d want 0", occ1); end
  endtask

  task automatic test_flush();
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data = 64'hD;
    tick();
    bus1.in_data = 64'hE;
    tick();
    checks++; if (occ1 !== 2'd2) begin errors++; $display("[TB] FAIL flush_pre_occ: got %0d want 2", occ1); end
    flush1 = 1'b1;
    bus1.in_data = 64'hF;
    tick();
    flush1 = 1'b0;
    bus1.in_valid = 1'b0;
    checks++; if (occ1 !== 2'd0) begin errors++; $display("[TB] FAIL flush_occ: got %0d want 0", occ1); end
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b want 0", bus1.out_valid); end
    checks++; if (bus1.out_data !== 64'h0000_0000_0000_0013) begin errors++; $display("[TB] FAIL flush_data: got %h want 13", bus1.out_data); end
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %b want 1", bus1.in_ready); end
    checks++; if (stall1 !== 4'd3) begin errors++; $display("[TB] FAIL flush_stall: got %0d want 3", stall1); end
  endtask

  task automatic test_stall_sat();
    int model;
    model = 3;
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data = 64'h6;
    tick();
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (model < 15) model++;
      checks++; if (stall1 !== 4'(model)) begin errors++; $display("[TB] FAIL stall_cyc%0d: got %0d want %0d", i, stall1, model); end
    end
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    checks++; if (stall1 !== 4'd15) begin errors++; $display("[TB] FAIL stall_flush: got %0d want 15", stall1); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("[TB] FAIL stall_flush_occ: got %0d want 0", occ1); end
  endtask

  task automatic test_back_to_back();
    bus0.out_ready = 1'b1;
    bus0.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus0.in_data = 64'h1000 + 64'(k);
      #1;
      checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready%0d: got %b want 1", k, bus0.in_ready); end
      tick();
      checks++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== 64'h1000 + 64'(k)) begin
        errors++; $display("[TB] FAIL b2b_out%0d: got v=%b %h want v=1 %h", k, bus0.out_valid, bus0.out_data, 64'h1000 + 64'(k));
      end
    end
    bus0.in_valid = 1'b0;
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b want 0", bus0.out_valid); end
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data = 64'h77;
    tick();
    checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_full_ready: got %b want 0", bus0.in_ready); end
    bus0.out_ready = 1'b1;
    #1;
    checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_comb_ready: got %b want 1", bus0.in_ready); end
    bus0.in_valid = 1'b0;
    tick();
    checks++; if (sb0.size() != 0) begin errors++; $display("[TB] FAIL sb0_left: got %0d entries want 0", sb0.size()); end
  endtask

  task automatic test_reset_in_two();
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data = 64'h8;
    tick();
    bus1.in_data = 64'h9;
    tick();
    bus1.in_valid = 1'b0;
    checks++; if (occ1 !== 2'd2) begin errors++; $display("[TB] FAIL r2_pre_occ: got %0d want 2", occ1); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL r2_async_valid: got %b want 0", bus1.out_valid); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("[TB] FAIL r2_async_occ: got %0d want 0", occ1); end
    checks++; if (stall1 !== 4'd0) begin errors++; $display("[TB] FAIL r2_async_stall: got %0d want 0", stall1); end
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL r2_async_ready: got %b want 0", bus1.in_ready); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus1.out_data !== NOP) begin errors++; $display("[TB] FAIL r2_rel_data: got %h want %h", bus1.out_data, NOP); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("[TB] FAIL r2_rel_occ: got %0d want 0", occ1); end
    tick();
    checks++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL r2_after: got v=%b r=%b want v=0 r=1", bus1.out_valid, bus1.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_skid_fill();
    test_flush();
    test_stall_sat();
    test_back_to_back();
    test_reset_in_two();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
